// File: rtl/deser_pkg.sv
// Shared constants and state encoding for the serial-link deserializer.
package deser_pkg;
    localparam int WORD_W    = 16;
    localparam int BIT_IDX_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Latency: a pushed word is visible on dout after the push edge.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end
endmodule

// File: rtl/deserializer.sv
// Serial-to-16-bit deserializer with frame length/runt checks; DESER_MSB_FIRST_EN selects MSB-first packing.
// Latency: word valid on data_o right after the edge that samples its 16th bit.
// Backpressure: valid/ready on the output FIFO; a word arriving at a full FIFO is dropped and overflow_o latches.
module deserializer
    import deser_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid_in,
    input  logic [LEN_W-1:0]  expected_len_in,
    output logic [WORD_W-1:0] data_o,
    output logic              data_valid_o,
    input  logic              data_ready_in,
    output logic              frame_done_o,
    output logic [LEN_W-1:0]  frame_len_o,
    output logic              len_err_o,
    output logic              runt_err_o,
    output logic              overflow_o
);
    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    state_t                 state;
    logic [WORD_W-1:0]      shift_reg;
    logic [WORD_W-1:0]      shift_nxt;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic [LEN_W-1:0]       word_cnt;
    logic [LEN_W-1:0]       exp_len;
    logic                   word_push;
    logic                   fifo_pop;
    logic                   fifo_empty;
    logic                   fifo_full;

`ifdef DESER_MSB_FIRST_EN
    assign shift_nxt = {shift_reg[WORD_W-2:0], bit_in};
`else
    assign shift_nxt = {bit_in, shift_reg[WORD_W-1:1]};
`endif

    // The completed word is exactly the shift value that includes the current bit.
    assign word_push    = (state == ST_RECV) && bit_valid_in
                          && (bit_idx == BIT_IDX_W'(WORD_W-1));
    assign fifo_pop     = data_ready_in && !fifo_empty;
    assign data_valid_o = !fifo_empty;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (word_push),
        .push_data (shift_nxt),
        .pop       (fifo_pop),
        .dout      (data_o),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            shift_reg    <= '0;
            bit_idx      <= '0;
            word_cnt     <= '0;
            exp_len      <= '0;
            frame_done_o <= 1'b0;
            frame_len_o  <= '0;
            len_err_o    <= 1'b0;
            runt_err_o   <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            len_err_o    <= 1'b0;
            runt_err_o   <= 1'b0;
            if (word_push && fifo_full && !fifo_pop) begin
                overflow_o <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (bit_valid_in) begin
                        state     <= ST_RECV;
                        shift_reg <= shift_nxt;
                        bit_idx   <= BIT_IDX_W'(1);
                        word_cnt  <= '0;
                        exp_len   <= expected_len_in;
                    end
                end
                ST_RECV: begin
                    if (bit_valid_in) begin
                        shift_reg <= shift_nxt;
                        bit_idx   <= bit_idx + 1'b1;
                        if (word_push && (word_cnt != CNT_MAX)) begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end else begin
                        // Any partial word is simply abandoned in the shift register.
                        state        <= ST_IDLE;
                        frame_done_o <= 1'b1;
                        frame_len_o  <= word_cnt;
                        len_err_o    <= (word_cnt != exp_len);
                        runt_err_o   <= (bit_idx != '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_deserializer.sv
// Randomized and directed bench for deserializer against a frame-level bit-queue model.
module tb_deserializer;
    localparam int DEPTH   = 4;
    localparam int LEN_W   = 8;
    localparam int MAX_LEN = (1 << LEN_W) - 1;

`ifdef DESER_MSB_FIRST_EN
    localparam logic [15:0] W1 = 16'hC3A5;
    localparam logic [15:0] W2 = 16'hF0F0;
    localparam logic [15:0] W3 = 16'h2C48;
`else
    localparam logic [15:0] W1 = 16'hA5C3;
    localparam logic [15:0] W2 = 16'h0F0F;
    localparam logic [15:0] W3 = 16'h1234;
`endif

    logic             clk;
    logic             rst_n;
    logic             bit_in;
    logic             bit_valid_in;
    logic [LEN_W-1:0] expected_len_in;
    logic [15:0]      data_o;
    logic             data_valid_o;
    logic             data_ready_in;
    logic             frame_done_o;
    logic [LEN_W-1:0] frame_len_o;
    logic             len_err_o;
    logic             runt_err_o;
    logic             overflow_o;

    deserializer #(.FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bit_in          (bit_in),
        .bit_valid_in    (bit_valid_in),
        .expected_len_in (expected_len_in),
        .data_o          (data_o),
        .data_valid_o    (data_valid_o),
        .data_ready_in   (data_ready_in),
        .frame_done_o    (frame_done_o),
        .frame_len_o     (frame_len_o),
        .len_err_o       (len_err_o),
        .runt_err_o      (runt_err_o),
        .overflow_o      (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: frame-level view of the link.
    logic [15:0] mq[$];
    bit          wbits[$];
    int          m_nbits, m_exp, m_len;
    bit          m_in_frame, m_done, m_lenerr, m_runt, m_ovf;

    // Observations captured from the DUT for directed literal checks.
    logic [15:0] got[$];
    int          done_lens[$];
    int          done_errs[$];

    function automatic logic [15:0] xf(input logic [15:0] v);
        logic [15:0] r;
`ifdef DESER_MSB_FIRST_EN
        for (int i = 0; i < 16; i++) r[15-i] = v[i];
`else
        r = v;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit bv, input bit b, input bit rdy, input int exp);
        bit          do_pop;
        bit          have_word;
        logic [15:0] w;
        if (!r) begin
            mq.delete(); wbits.delete();
            m_in_frame = 0; m_nbits = 0; m_exp = 0; m_len = 0;
            m_done = 0; m_lenerr = 0; m_runt = 0; m_ovf = 0;
            return;
        end
        m_done = 0; m_lenerr = 0; m_runt = 0;
        do_pop    = rdy && (mq.size() != 0);
        have_word = 0;
        w         = '0;
        if (bv) begin
            if (!m_in_frame) begin
                m_in_frame = 1; m_nbits = 0; m_exp = exp; wbits.delete();
            end
            wbits.push_back(b);
            m_nbits++;
            if (wbits.size() == 16) begin
                for (int i = 0; i < 16; i++) begin
`ifdef DESER_MSB_FIRST_EN
                    w[15-i] = wbits[i];
`else
                    w[i] = wbits[i];
`endif
                end
                wbits.delete();
                have_word = 1;
            end
        end else if (m_in_frame) begin
            m_in_frame = 0;
            m_len    = (m_nbits / 16 > MAX_LEN) ? MAX_LEN : m_nbits / 16;
            m_done   = 1;
            m_lenerr = (m_len != m_exp);
            m_runt   = (m_nbits % 16) != 0;
        end
        if (do_pop) void'(mq.pop_front());
        if (have_word) begin
            if (mq.size() < DEPTH) mq.push_back(w);
            else m_ovf = 1;
        end
    endtask

    // One clock: drive inputs, advance model, then compare at the falling edge.
    task automatic cyc(input bit r, input bit bv, input bit b, input bit rdy, input int exp);
        if (rdy && data_valid_o) got.push_back(data_o);
        rst_n = r; bit_valid_in = bv; bit_in = b; data_ready_in = rdy;
        expected_len_in = LEN_W'(exp);
        model_step(r, bv, b, rdy, exp);
        @(posedge clk);
        @(negedge clk);
        vectors++;
        chk("valid", data_valid_o, mq.size() != 0);
        if (mq.size() != 0 && data_valid_o) chk("data", data_o, mq[0]);
        chk("frame_done", frame_done_o, m_done);
        chk("frame_len", frame_len_o, m_len);
        chk("len_err", len_err_o, m_lenerr);
        chk("runt_err", runt_err_o, m_runt);
        chk("overflow", overflow_o, m_ovf);
        if (frame_done_o) begin
            done_lens.push_back(int'(frame_len_o));
            done_errs.push_back(int'(len_err_o));
        end
    endtask

    task automatic send_word(input logic [15:0] w, input bit rdy, input int exp);
        for (int i = 0; i < 16; i++) cyc(1, 1, w[i], rdy, exp);
    endtask

    logic [15:0] wd[5];

    initial begin
        rst_n = 0; bit_in = 0; bit_valid_in = 0; data_ready_in = 0; expected_len_in = '0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_valid", data_valid_o, 0);
        chk("rst_len", frame_len_o, 0);
        chk("rst_ovf", overflow_o, 0);

        // Two-word frame, LSB-first stream of A5C3 then 0F0F.
        send_word(16'hA5C3, 1, 2);
        chk("t1_w0_valid", data_valid_o, 1);
        chk("t1_w0", data_o, W1);
        send_word(16'h0F0F, 1, 2);
        chk("t1_w1_valid", data_valid_o, 1);
        chk("t1_w1", data_o, W2);
        cyc(1, 0, 0, 1, 2);
        chk("t1_done", frame_done_o, 1);
        chk("t1_len", frame_len_o, 2);
        chk("t1_lenerr", len_err_o, 0);
        chk("t1_runt", runt_err_o, 0);

        // Runt: 20 bits.
        send_word(16'h5AA5, 1, 1);
        for (int i = 0; i < 4; i++) cyc(1, 1, i[0], 1, 1);
        cyc(1, 0, 0, 1, 1);
        chk("t2_done", frame_done_o, 1);
        chk("t2_runt", runt_err_o, 1);
        chk("t2_len", frame_len_o, 1);
        chk("t2_lenerr", len_err_o, 0);
        cyc(1, 0, 0, 1, 0);

        // Overflow: 5 words into a 4-deep FIFO with no consumer.
        for (int k = 0; k < 5; k++) wd[k] = 16'($urandom);
        for (int k = 0; k < 5; k++) send_word(wd[k], 0, 5);
        cyc(1, 0, 0, 0, 5);
        cyc(1, 0, 0, 0, 5);
        chk("t3_ovf", overflow_o, 1);
        got.delete();
        for (int k = 0; k < 8; k++) cyc(1, 0, 0, 1, 0);
        chk("t3_drain_cnt", got.size(), 4);
        if (got.size() == 4)
            for (int k = 0; k < 4; k++) chk("t3_drain_word", got[k], xf(wd[k]));
        chk("t3_ovf_sticky", overflow_o, 1);

        // Full boundary: 16th bit of the fifth word coincides with a pop.
        cyc(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) wd[k] = 16'($urandom);
        for (int k = 0; k < 4; k++) send_word(wd[k], 0, 5);
        for (int i = 0; i < 16; i++) cyc(1, 1, wd[4][i], i == 15, 5);
        cyc(1, 0, 0, 0, 5);
        chk("t4_ovf", overflow_o, 0);
        got.delete();
        for (int k = 0; k < 10; k++) cyc(1, 0, 0, 1, 0);
        chk("t4_occupancy", got.size(), 4);
        if (got.size() == 4) begin
            chk("t4_first", got[0], xf(wd[1]));
            chk("t4_last", got[3], xf(wd[4]));
        end

        // Back-to-back frames of 1 and 3 words separated by one idle cycle.
        done_lens.delete(); done_errs.delete();
        send_word(16'($urandom), 1, 3);
        cyc(1, 0, 0, 1, 3);
        for (int k = 0; k < 3; k++) send_word(16'($urandom), 1, 3);
        cyc(1, 0, 0, 1, 3);
        cyc(1, 0, 0, 1, 0);
        chk("t5_pulses", done_lens.size(), 2);
        if (done_lens.size() == 2) begin
            chk("t5_len0", done_lens[0], 1);
            chk("t5_len1", done_lens[1], 3);
            chk("t5_err0", done_errs[0], 1);
            chk("t5_err1", done_errs[1], 0);
        end

        // Reset mid-frame with a word still buffered, then a clean frame.
        send_word(16'hBEEF, 0, 1);
        cyc(1, 0, 0, 0, 1);
        done_lens.delete();
        for (int i = 0; i < 8; i++) cyc(1, 1, i[1], 0, 1);
        cyc(0, 1, 0, 0, 1);
        chk("t6_empty", data_valid_o, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t6_no_pulse", done_lens.size(), 0);
        chk("t6_len_rst", frame_len_o, 0);
        send_word(16'h1234, 0, 1);
        chk("t6_word", data_o, W3);
        cyc(1, 0, 0, 1, 1);
        chk("t6_len", frame_len_o, 1);
        chk("t6_lenerr", len_err_o, 0);
        cyc(1, 0, 0, 1, 0);

        // Word count saturation: 256 words in one frame.
        for (int k = 0; k < 256; k++) send_word(16'($urandom), 1, MAX_LEN);
        cyc(1, 0, 0, 1, MAX_LEN);
        chk("sat_len", frame_len_o, MAX_LEN);
        chk("sat_lenerr", len_err_o, 0);

        // Randomized frames, gaps, consumer stalls and occasional resets.
        for (int f = 0; f < 250; f++) begin
            int nb, ex, gap;
            nb  = $urandom_range(70, 1);
            ex  = $urandom_range(4, 0);
            gap = $urandom_range(3, 1);
            if ($urandom_range(39, 0) == 0) cyc(0, 0, 0, 0, 0);
            for (int i = 0; i < nb; i++)
                cyc(1, 1, 1'($urandom), $urandom_range(3, 0) != 0, ex);
            for (int g = 0; g < gap; g++)
                cyc(1, 0, 0, $urandom_range(1, 0) == 1, ex);
        end
        for (int k = 0; k < 8; k++) cyc(1, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the bit serializer. Samples a serial bit stream plus bit-valid strobe on the serializer's forwarded clock.
- Reassembles 16-bit words, first received bit = word bit 0.
- Buffers words in a small FIFO with a valid/ready output.
- Reports per-frame word count and framing errors.
- Sits at the receive end of the serial link, feeding the parallel data path.

Parameters:
- FIFO_DEPTH, 16: output FIFO depth in words. Power of 2, range 4..256.
- LEN_W, 8: width of the frame length count and expected-length input.

Ports:
- clk  in  1  sample clock. This is the transmitter's forwarded bit clock.
- rst_n  in  1  reset. Synchronous, active-low.
- bit_in  in  1  serial data bit.
- bit_valid_in  in  1  bit qualifier. High for the whole frame.
- expected_len_in  in  LEN_W  expected words per frame. Sampled on the frame's first bit.
- data_o  out  16  assembled word at the FIFO head.
- data_valid_o  out  1  FIFO not empty.
- data_ready_in  in  1  consumer accepts data_o when data_valid_o and data_ready_in are both high.
- frame_done_o  out  1  one-cycle pulse at frame end.
- frame_len_o  out  LEN_W  words received in the last frame. Held until the next frame_done_o.
- len_err_o  out  1  one-cycle pulse with frame_done_o when frame_len_o != expected length.
- runt_err_o  out  1  one-cycle pulse when a frame ends mid-word.
- overflow_o  out  1  sticky. Set when a word is dropped because the FIFO is full.

Behaviour:
- Reset (rst_n low at a clk edge): all outputs and state go to 0 and the FIFO is emptied. Reset mid-frame abandons the frame; no pulses are generated.
- States:
  - IDLE: bit_valid_in=1 -> RECV. On that edge, sample the first bit into bit 0, set bit_index=1, clear word_cnt, latch expected_len_in.
  - RECV, bit_valid_in=1: shift bit_in in. Shift reg shifts right, new bit enters [15], so the first bit ends up in [0].
    - When bit_index==15: push word {bit_in, shift_reg[15:1]} into the FIFO on the same edge, bit_index wraps to 0, word_cnt+1.
    - word_cnt saturates at 2^LEN_W-1.
  - RECV, bit_valid_in=0 with bit_index==0: frame end.
    - frame_done_o=1, frame_len_o=word_cnt.
    - len_err_o=(word_cnt!=latched expected length).
    - -> IDLE.
  - RECV, bit_valid_in=0 with bit_index!=0: runt.
    - Partial word discarded, runt_err_o=1, frame_done_o=1, frame_len_o=complete words only, len_err_o evaluated as above.
    - -> IDLE.
- Latency: 16th bit sampled at edge N -> data_valid_o high after edge N (FIFO is first-word-fall-through).
- Matching transmitter: a transmitter holding bit_valid high for L*16 cycles yields exactly L words, then frame_done_o one cycle after the last bit.
- FIFO full and push with no simultaneous pop: word dropped, overflow_o set. overflow_o clears only on reset.
- FIFO full and simultaneous push + pop: both occur, no drop.
- FIFO empty: data_ready_in is ignored and data_o is don't-care.
- Pointers wrap modulo FIFO_DEPTH. Occupancy count width is log2(FIFO_DEPTH)+1.
- Back-to-back frames: bit_valid_in low for a single cycle is enough to separate two frames. The IDLE->RECV transition on the next high cycle is legal immediately.

Optional Feature:
- Macro: DESER_MSB_FIRST_EN.
- Defined: first received bit maps to word bit 15. Shift left, new bit enters [0], pushed word = {shift_reg[14:0], bit_in}.
- Undefined: LSB-first as above, matching the existing serializer.
- All other timing is identical in both builds.

Decomposition:
- Package deser_pkg:
  - WORD_W=16.
  - BIT_IDX_W=4.
  - State encoding constants ST_IDLE, ST_RECV.
- Sub-module sync_fifo:
  - Parameterized width and depth, first-word-fall-through.
  - Ports: push, push_data, pop, dout, empty, full.
  - Reusable elsewhere in the design.
- deserializer contains the FSM, shift register, counters and error logic.

Test Plan:
- Frame of 2 words, LSB first: bits for 16'hA5C3 then 16'h0F0F, expected_len_in=2, data_ready_in=1. Required: words 16'hA5C3 and 16'h0F0F, each valid 1 cycle after its 16th bit; frame_done_o with frame_len_o=2; len_err_o=0.
- Runt: bit_valid_in high for 20 bits, expected_len_in=1. Required: one word delivered, runt_err_o=1, frame_done_o=1, frame_len_o=1, len_err_o=0.
- Overflow: FIFO_DEPTH=4, data_ready_in=0, 5-word frame. Required: 4 words held; 5th dropped; overflow_o=1 stays high; draining gives words 1-4 in order.
- Full boundary: FIFO full, 16th bit arrives on the same cycle as a pop. Required: no drop, overflow_o stays 0, occupancy stays 4.
- Back-to-back frames of 1 and 3 words separated by a single low cycle, expected_len_in=3 both. Required: two frame_done_o pulses, frame_len_o 1 then 3, len_err_o=1 then 0.
- rst_n low mid-word during frame 1, then a clean 1-word frame 16'h1234. Required: no pulses from the aborted frame; FIFO empty after reset; then 16'h1234 delivered with frame_len_o=1. In the DESER_MSB_FIRST_EN build, the same bit stream yields the bit-reversed word 16'h2C48.
